// File: rtl/pkt_fifo_sf.sv
// rtl/pkt_fifo_sf.sv - packet FIFO with store-and-forward, error/oversize drop and framing repair
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_data/in_sop/in_eop/in_empty/in_err
//                         input beat payload and framing (in_err sampled on eop only)
//   out_valid/out_ready   output handshake, first-word-fall-through
//   out_data/out_sop/out_eop/out_empty/out_err
//                         entry at the read pointer; out_empty is 0 off eop, out_err is CT-only
//   fill_level            stored beats, including the not yet committed packet
//   pkt_count             committed packets (eop beats) stored
//   almost_full           fill_level >= ALMOST_FULL_TH
//   drop_cnt              dropped packets, saturating
module pkt_fifo_sf #(
  parameter int SYMBOL_PER_BEATS = 8,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int FIFO_DEPTH       = 512,
  parameter int STORE_FORWARD    = 1,
  parameter int ALMOST_FULL_TH   = FIFO_DEPTH - 16,
  parameter int EW               = (SYMBOL_PER_BEATS > 1) ? $clog2(SYMBOL_PER_BEATS) : 1,
  localparam int DW              = SYMBOL_PER_BEATS * BITS_PER_SYMBOL,
  localparam int AW              = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [EW-1:0] in_empty,
  input  logic          in_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic [EW-1:0] out_empty,
  output logic          out_err,
  output logic [AW:0]   fill_level,
  output logic [AW:0]   pkt_count,
  output logic          almost_full,
  output logic [15:0]   drop_cnt
);

  localparam bit        SF      = (STORE_FORWARD != 0);
  localparam int        ENW     = DW + EW + 3;
  localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_TH   = (AW+1)'(ALMOST_FULL_TH);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t         state, state_n;
  logic [AW:0]    rd_ptr, wr_ptr, wr_commit;
  logic [AW:0]    rd_ptr_n, wr_ptr_n, wr_commit_n, fill_n, base;
  logic [ENW-1:0] mem [FIFO_DEPTH];
  logic [ENW-1:0] rd_entry;
  logic           full, span_full, in_fire, out_fire, we;
  logic [1:0]     drop_amt;
  logic [16:0]    drop_sum;

  assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
  // the open packet alone fills the whole buffer: it can never commit
  assign span_full = (wr_ptr - wr_commit) == DEPTH_P;
  assign in_ready  = rst_n && ((state == DROP) || !full);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = rd_ptr != wr_commit;
  assign out_fire  = out_valid && out_ready;

  assign rd_entry  = mem[rd_ptr[AW-1:0]];
  assign out_data  = rd_entry[DW-1:0];
  assign out_sop   = rd_entry[DW];
  assign out_eop   = rd_entry[DW+1];
  assign out_empty = out_eop ? rd_entry[DW+2 +: EW] : '0;
  assign out_err   = SF ? 1'b0 : rd_entry[DW+2+EW];

  always_comb begin
    state_n  = state;
    base     = wr_ptr;
    we       = 1'b0;
    drop_amt = 2'd0;
    case (state)
      IDLE, DROP: begin
        if (in_fire) begin
          if (in_sop) begin
            if (SF && in_eop && in_err) begin
              drop_amt = 2'd1;
              state_n  = IDLE;
            end else begin
              we      = 1'b1;
              state_n = in_eop ? IDLE : PKT;
            end
          end else if (in_eop) begin
            // orphan tail in IDLE counts as a drop; in DROP it was already counted
            if (state == IDLE) drop_amt = 2'd1;
            state_n = IDLE;
          end
        end
      end
      PKT: begin
        if (SF && span_full) begin
          base     = wr_commit;
          drop_amt = 2'd1;
          state_n  = DROP;
        end else if (in_fire) begin
          if (in_sop) begin
            // missing eop: SF discards the unterminated packet, CT just keeps writing
            if (SF) begin
              base     = wr_commit;
              drop_amt = 2'd1;
            end
            if (SF && in_eop && in_err) begin
              drop_amt = 2'd2;
              state_n  = IDLE;
            end else begin
              we = 1'b1;
              if (in_eop) state_n = IDLE;
            end
          end else if (SF && in_eop && in_err) begin
            base     = wr_commit;
            drop_amt = 2'd1;
            state_n  = IDLE;
          end else begin
            we = 1'b1;
            if (in_eop) state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    wr_ptr_n    = we ? base + (AW+1)'(1) : base;
    if (SF) wr_commit_n = (we && in_eop) ? wr_ptr_n : wr_commit;
    else    wr_commit_n = wr_ptr_n;
    rd_ptr_n    = rd_ptr + (AW+1)'(out_fire);
    fill_n      = wr_ptr_n - rd_ptr_n;
    drop_sum    = {1'b0, drop_cnt} + 17'(drop_amt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      wr_commit   <= '0;
      fill_level  <= '0;
      almost_full <= 1'b0;
      pkt_count   <= '0;
      drop_cnt    <= '0;
    end else begin
      rd_ptr      <= rd_ptr_n;
      wr_ptr      <= wr_ptr_n;
      wr_commit   <= wr_commit_n;
      fill_level  <= fill_n;
      almost_full <= fill_n >= AF_TH;
      drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      // every written eop beat is committed in both modes
      case ({we && in_eop, out_fire && out_eop})
        2'b10:   pkt_count <= pkt_count + (AW+1)'(1);
        2'b01:   pkt_count <= pkt_count - (AW+1)'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[base[AW-1:0]] <= {in_err & in_eop, in_empty, in_eop, in_sop, in_data};
  end

endmodule

// File: tb/tb_pkt_fifo_sf.sv
// tb/tb_pkt_fifo_sf.sv - self-checking bench for pkt_fifo_sf in store-and-forward and cut-through modes
module tb_pkt_fifo_sf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [2:0]  in_empty = '0;

  logic        sf_in_ready, sf_out_valid, sf_out_sop, sf_out_eop, sf_out_err, sf_af;
  logic [63:0] sf_out_data;
  logic [2:0]  sf_out_empty;
  logic [3:0]  sf_fill, sf_pkt;
  logic [15:0] sf_drop;
  logic        ct_in_ready, ct_out_valid, ct_out_sop, ct_out_eop, ct_out_err, ct_af;
  logic [63:0] ct_out_data;
  logic [2:0]  ct_out_empty;
  logic [3:0]  ct_fill, ct_pkt;
  logic [15:0] ct_drop;

  logic        o_in_ready, o_valid, o_sop, o_eop, o_err, o_af;
  logic [63:0] o_data;
  logic [2:0]  o_empty;
  logic [3:0]  o_fill, o_pkt;
  logic [15:0] o_drop;

  int total = 0, bad = 0, stalls = 0;

  always #5 clk = ~clk;

  pkt_fifo_sf #(.SYMBOL_PER_BEATS(8), .BITS_PER_SYMBOL(8), .FIFO_DEPTH(8),
                .STORE_FORWARD(1), .ALMOST_FULL_TH(6)) u_sf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(sf_in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_err(in_err),
    .out_valid(sf_out_valid), .out_ready(out_ready && !sel), .out_data(sf_out_data),
    .out_sop(sf_out_sop), .out_eop(sf_out_eop), .out_empty(sf_out_empty), .out_err(sf_out_err),
    .fill_level(sf_fill), .pkt_count(sf_pkt), .almost_full(sf_af), .drop_cnt(sf_drop));

  pkt_fifo_sf #(.SYMBOL_PER_BEATS(8), .BITS_PER_SYMBOL(8), .FIFO_DEPTH(8),
                .STORE_FORWARD(0), .ALMOST_FULL_TH(4)) u_ct (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(ct_in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_err(in_err),
    .out_valid(ct_out_valid), .out_ready(out_ready && sel), .out_data(ct_out_data),
    .out_sop(ct_out_sop), .out_eop(ct_out_eop), .out_empty(ct_out_empty), .out_err(ct_out_err),
    .fill_level(ct_fill), .pkt_count(ct_pkt), .almost_full(ct_af), .drop_cnt(ct_drop));

  assign o_in_ready = sel ? ct_in_ready  : sf_in_ready;
  assign o_valid    = sel ? ct_out_valid : sf_out_valid;
  assign o_data     = sel ? ct_out_data  : sf_out_data;
  assign o_sop      = sel ? ct_out_sop   : sf_out_sop;
  assign o_eop      = sel ? ct_out_eop   : sf_out_eop;
  assign o_empty    = sel ? ct_out_empty : sf_out_empty;
  assign o_err      = sel ? ct_out_err   : sf_out_err;
  assign o_fill     = sel ? ct_fill      : sf_fill;
  assign o_pkt      = sel ? ct_pkt       : sf_pkt;
  assign o_af       = sel ? ct_af        : sf_af;
  assign o_drop     = sel ? ct_drop      : sf_drop;

  typedef struct {
    logic iv, isop, ieop; logic [2:0] iemp; logic ierr; logic [63:0] idata; logic ordy;
    logic e_ov, e_sop, e_eop; logic [2:0] e_emp; logic [63:0] e_data;
    logic [3:0] e_fill, e_pkt; logic [15:0] e_drop;
  } vec_t;
  vec_t tbl [11];

  typedef struct { logic [63:0] d; logic s, e; logic [2:0] m; logic r; } beat_t;
  beat_t exp_q[$];
  beat_t pend_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 0; in_sop = 0; in_eop = 0; in_err = 0; out_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic send(input logic s, input logic e, input logic [2:0] m, input logic r,
                      input logic [63:0] d);
    int w;
    @(negedge clk);
    in_valid = 1; in_sop = s; in_eop = e; in_empty = m; in_err = r; in_data = d;
    #1;
    w = 0;
    while (!o_in_ready && w < 50) begin
      @(negedge clk); #1; w++; stalls++;
    end
    if (!o_in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept data=%0h", d);
    end else @(posedge clk);
    #1;
    in_valid = 0; in_sop = 0; in_eop = 0; in_err = 0;
  endtask

  task automatic recv(input string nm, input logic [63:0] d, input logic s, input logic e,
                      input logic [2:0] m, input logic r);
    int w;
    @(negedge clk);
    out_ready = 1;
    #1;
    w = 0;
    while (!o_valid && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (!o_valid) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=out_valid_low expected=beat %0h", nm, d);
    end else begin
      chk({nm, "_data"}, o_data, d);
      chk({nm, "_sop"}, o_sop, s);
      chk({nm, "_eop"}, o_eop, e);
      chk({nm, "_empty"}, o_empty, m);
      chk({nm, "_err"}, o_err, r);
      @(posedge clk);
    end
    #1;
    out_ready = 0;
  endtask

  task automatic run_rand(input logic mode, input int ncyc);
    logic have, ifire, ofire;
    logic bs, be, br;
    logic [2:0] bm;
    logic [63:0] bd;
    int rem, idx, pkt_m, drop_m, fill_m, th;
    beat_t b;
    sel = mode;
    exp_q.delete(); pend_q.delete();
    have = 0; rem = 0; idx = 0; pkt_m = 0; drop_m = 0;
    bs = 0; be = 0; br = 0; bm = 0; bd = 0;
    th = mode ? 4 : 6;
    for (int cyc = 0; cyc < ncyc + 300; cyc++) begin
      @(negedge clk);
      fill_m = exp_q.size() + pend_q.size();
      chk("rnd_out_valid", o_valid, exp_q.size() != 0);
      chk("rnd_fill", o_fill, 64'(fill_m));
      chk("rnd_pkt", o_pkt, 64'(pkt_m));
      chk("rnd_drop", o_drop, 64'(drop_m));
      chk("rnd_af", o_af, fill_m >= th);
      if (cyc >= ncyc && !have && rem == 0 && exp_q.size() == 0) break;
      if (!have && (cyc < ncyc || rem > 0) && $urandom_range(3) != 0) begin
        if (rem == 0) begin rem = $urandom_range(6, 1); idx = 0; end
        bs = (idx == 0); be = (rem == 1);
        bm = 3'($urandom); br = ($urandom_range(3) == 0);
        bd = {$urandom, $urandom};
        have = 1; idx++; rem--;
      end
      in_valid = have; in_sop = bs; in_eop = be; in_empty = bm; in_err = br; in_data = bd;
      out_ready = ($urandom_range(3) != 0);
      #1;
      ofire = o_valid && out_ready;
      ifire = have && o_in_ready;
      if (ofire && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("rnd_o_data", o_data, b.d);
        chk("rnd_o_sop", o_sop, b.s);
        chk("rnd_o_eop", o_eop, b.e);
        chk("rnd_o_empty", o_empty, b.m);
        chk("rnd_o_err", o_err, b.r);
        if (b.e) pkt_m--;
      end
      if (ifire) begin
        b.d = bd; b.s = bs; b.e = be; b.m = be ? bm : 3'd0; b.r = mode && be && br;
        if (mode) begin
          exp_q.push_back(b);
          if (be) pkt_m++;
        end else begin
          pend_q.push_back(b);
          if (be && br) begin
            drop_m++;
            pend_q.delete();
          end else if (be) begin
            while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
            pkt_m++;
          end
        end
        have = 0;
      end
    end
    in_valid = 0; out_ready = 0;
    chk("rnd_drained", 64'(exp_q.size() + pend_q.size() + rem + int'(have)), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,1,0,0,0,'hA0,1, 0,0,0,0,0,   0,0,0};
    tbl[1]  = '{1,0,0,0,0,'hA1,1, 0,0,0,0,0,   1,0,0};
    tbl[2]  = '{1,0,1,3,0,'hA2,1, 0,0,0,0,0,   2,0,0};
    tbl[3]  = '{0,0,0,0,0,0,1,    1,1,0,0,'hA0, 3,1,0};
    tbl[4]  = '{0,0,0,0,0,0,1,    1,0,0,0,'hA1, 2,1,0};
    tbl[5]  = '{0,0,0,0,0,0,1,    1,0,1,3,'hA2, 1,1,0};
    tbl[6]  = '{1,1,0,0,0,'hB0,1, 0,0,0,0,0,   0,0,0};
    tbl[7]  = '{1,0,0,0,0,'hB1,1, 0,0,0,0,0,   1,0,0};
    tbl[8]  = '{1,0,0,0,0,'hB2,1, 0,0,0,0,0,   2,0,0};
    tbl[9]  = '{1,0,1,2,1,'hB3,1, 0,0,0,0,0,   3,0,0};
    tbl[10] = '{0,0,0,0,0,0,1,    0,0,0,0,0,   0,0,1};

    // reset state
    #1;
    chk("rst_in_ready_low", sf_in_ready, 0);
    do_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      chk($sformatf("rst%0d_out_valid", s), o_valid, 0);
      chk($sformatf("rst%0d_fill", s), o_fill, 0);
      chk($sformatf("rst%0d_pkt", s), o_pkt, 0);
      chk($sformatf("rst%0d_af", s), o_af, 0);
      chk($sformatf("rst%0d_drop", s), o_drop, 0);
      chk($sformatf("rst%0d_in_ready", s), o_in_ready, 1);
    end

    // SF good packet then errored packet, table driven
    sel = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_sop = tbl[i].isop; in_eop = tbl[i].ieop;
      in_empty = tbl[i].iemp; in_err = tbl[i].ierr; in_data = tbl[i].idata;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_out_valid", i), o_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_fill", i), o_fill, tbl[i].e_fill);
      chk($sformatf("tbl%0d_pkt", i), o_pkt, tbl[i].e_pkt);
      chk($sformatf("tbl%0d_drop", i), o_drop, tbl[i].e_drop);
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_sop", i), o_sop, tbl[i].e_sop);
        chk($sformatf("tbl%0d_eop", i), o_eop, tbl[i].e_eop);
        chk($sformatf("tbl%0d_empty", i), o_empty, tbl[i].e_emp);
        chk($sformatf("tbl%0d_data", i), o_data, tbl[i].e_data);
      end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0;

    // SF oversize packet: 12 beats into 8 entries
    do_reset();
    sel = 0; stalls = 0;
    for (int i = 0; i < 12; i++) send(i == 0, i == 11, 0, 0, 64'h100 + 64'(i));
    chk("ovs_stalls", 64'(stalls), 1);
    chk("ovs_drop", o_drop, 1);
    chk("ovs_fill", o_fill, 0);
    chk("ovs_out_valid", o_valid, 0);
    send(1, 0, 0, 0, 64'h200);
    send(0, 1, 5, 0, 64'h201);
    chk("ovs_pkt", o_pkt, 1);
    recv("ovs_b0", 64'h200, 1, 0, 0, 0);
    recv("ovs_b1", 64'h201, 0, 1, 5, 0);
    chk("ovs_pkt_after", o_pkt, 0);

    // SF sop mid-packet, then orphan eop
    do_reset();
    sel = 0;
    send(1, 0, 0, 0, 64'h300);
    send(0, 0, 0, 0, 64'h301);
    send(1, 0, 0, 0, 64'h310);
    send(0, 0, 0, 0, 64'h311);
    send(0, 1, 2, 0, 64'h312);
    chk("mid_drop", o_drop, 1);
    chk("mid_pkt", o_pkt, 1);
    chk("mid_fill", o_fill, 3);
    send(0, 1, 0, 0, 64'h3FF);
    chk("orphan_drop", o_drop, 2);
    chk("orphan_fill", o_fill, 3);
    recv("mid_b0", 64'h310, 1, 0, 0, 0);
    recv("mid_b1", 64'h311, 0, 0, 0, 0);
    recv("mid_b2", 64'h312, 0, 1, 2, 0);
    chk("mid_out_valid_end", o_valid, 0);

    // CT fill to full, latency, almost_full, err passthrough
    do_reset();
    sel = 1;
    for (int k = 1; k <= 8; k++) begin
      send(k == 1, k == 8, (k == 8) ? 3'd6 : 3'd0, k == 8, 64'h400 + 64'(k));
      chk($sformatf("ct%0d_fill", k), o_fill, 64'(k));
      chk($sformatf("ct%0d_af", k), o_af, k >= 4);
      chk($sformatf("ct%0d_in_ready", k), o_in_ready, k < 8);
      if (k == 1) chk("ct_first_out_valid", o_valid, 1);
    end
    chk("ct_pkt", o_pkt, 1);
    @(negedge clk);
    in_valid = 1; in_sop = 0; in_eop = 0; in_data = 64'h4FF;
    @(posedge clk); #1;
    chk("ct_full_no_write", o_fill, 8);
    in_valid = 0;
    for (int k = 1; k <= 8; k++)
      recv($sformatf("ct_b%0d", k), 64'h400 + 64'(k), k == 1, k == 8,
           (k == 8) ? 3'd6 : 3'd0, k == 8);
    chk("ct_drain_fill", o_fill, 0);
    chk("ct_drain_pkt", o_pkt, 0);

    // asynchronous reset mid-packet
    do_reset();
    sel = 1;
    for (int i = 0; i < 5; i++) send(i == 0, 0, 0, 0, 64'h500 + 64'(i));
    sel = 0;
    send(0, 1, 0, 0, 64'h5FF);
    for (int i = 0; i < 5; i++) send(i == 0, 0, 0, 0, 64'h510 + 64'(i));
    chk("ar_sf_fill_pre", o_fill, 5);
    chk("ar_sf_drop_pre", o_drop, 1);
    sel = 1; #1;
    chk("ar_ct_ov_pre", o_valid, 1);
    chk("ar_ct_af_pre", o_af, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("ar_ct_ov", o_valid, 0);
    chk("ar_ct_fill", o_fill, 0);
    chk("ar_ct_af", o_af, 0);
    chk("ar_ct_in_ready", o_in_ready, 0);
    sel = 0; #1;
    chk("ar_sf_fill", o_fill, 0);
    chk("ar_sf_drop", o_drop, 0);
    chk("ar_sf_pkt", o_pkt, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    send(1, 0, 0, 0, 64'h600);
    send(0, 1, 1, 0, 64'h601);
    recv("ar_b0", 64'h600, 1, 0, 0, 0);
    recv("ar_b1", 64'h601, 0, 1, 1, 0);

    // randomized traffic against the queue model
    do_reset();
    run_rand(1'b0, 400);
    do_reset();
    run_rand(1'b1, 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
